// File: rtl/sample_rate_scheduler.sv
`timescale 1ns/1ps
// sample_rate_scheduler
// Buffers PCM samples that arrive in bursts and releases one every DIV clocks.
// Playback starts or resumes once PREFILL samples are buffered. Underruns
// and dropped samples are counted and shown on stretched LEDs.
// Ports:
//   input_clk, reset_n  : clock, async active-low reset
//   in_valid, in_data   : one-cycle sample write from the SPI receiver
//   out_sample          : sample for the DSP/DAC, updated on each strobe
//   out_strobe          : one-cycle pulse when out_sample updates
//   fill_level          : FIFO occupancy
//   underrun_count      : saturating underrun count
//   overflow_count      : saturating dropped-sample count
//   RED_LED/BLUE_LED    : stretched underrun / overflow indicators
//   GREEN_LED           : high while playing
module sample_rate_scheduler #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned PREFILL  = 4,
  parameter int unsigned DIV      = 256,
  parameter int unsigned LED_HOLD = 1228800
) (
  input  logic                     input_clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic [DATA_W-1:0]        out_sample,
  output logic                     out_strobe,
  output logic [$clog2(DEPTH):0]   fill_level,
  output logic [15:0]              underrun_count,
  output logic [15:0]              overflow_count,
  output logic                     RED_LED,
  output logic                     GREEN_LED,
  output logic                     BLUE_LED
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned TICK_W = $clog2(DIV);
  localparam int unsigned LED_W  = $clog2(LED_HOLD + 1);

  typedef enum logic {ST_PREFILL = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              state, n_state;
  logic [TICK_W-1:0]   tick_cnt, n_tick_cnt;
  logic [PTR_W-1:0]    wr_ptr, n_wr_ptr, rd_ptr, n_rd_ptr;
  logic [FILL_W-1:0]   n_fill;
  logic [DATA_W-1:0]   n_out_sample;
  logic                n_strobe;
  logic [15:0]         n_under_cnt, n_over_cnt;
  logic [LED_W-1:0]    red_cnt, n_red_cnt, blue_cnt, n_blue_cnt;
  logic                tick, pop, push, drop, underrun;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Next-state and output decode; pop decisions use the pre-push fill level.
  always_comb begin
    n_state      = state;
    n_out_sample = out_sample;
    n_strobe     = 1'b0;
    pop          = 1'b0;
    underrun     = 1'b0;

    tick       = (tick_cnt == TICK_W'(DIV - 1));
    n_tick_cnt = tick ? '0 : tick_cnt + TICK_W'(1);

    if (tick) begin
      n_strobe = 1'b1;
      if (state == ST_PREFILL) begin
        if (fill_level >= FILL_W'(PREFILL)) begin
          pop          = 1'b1;
          n_out_sample = mem[rd_ptr];
          n_state      = ST_RUN;
        end else begin
          n_out_sample = '0;
        end
      end else begin
        if (fill_level != '0) begin
          pop          = 1'b1;
          n_out_sample = mem[rd_ptr];
        end else begin
          underrun = 1'b1;
          n_state  = ST_PREFILL;
        end
      end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    push = in_valid && ((fill_level != FILL_W'(DEPTH)) || pop);
    drop = in_valid && !push;

    n_wr_ptr = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    n_rd_ptr = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    n_fill   = fill_level + FILL_W'(push) - FILL_W'(pop);

    n_under_cnt = (underrun && underrun_count != 16'hFFFF) ? underrun_count + 16'd1 : underrun_count;
    n_over_cnt  = (drop && overflow_count != 16'hFFFF) ? overflow_count + 16'd1 : overflow_count;

    // LED stretchers: reload on event, otherwise count down to zero.
    if (underrun)           n_red_cnt = LED_W'(LED_HOLD);
    else if (red_cnt != '0) n_red_cnt = red_cnt - LED_W'(1);
    else                    n_red_cnt = red_cnt;

    if (drop)                n_blue_cnt = LED_W'(LED_HOLD);
    else if (blue_cnt != '0) n_blue_cnt = blue_cnt - LED_W'(1);
    else                     n_blue_cnt = blue_cnt;
  end

  // State and output registers.
  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_PREFILL;
      tick_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      out_sample     <= '0;
      out_strobe     <= 1'b0;
      underrun_count <= '0;
      overflow_count <= '0;
      red_cnt        <= '0;
      blue_cnt       <= '0;
      RED_LED        <= 1'b0;
      GREEN_LED      <= 1'b0;
      BLUE_LED       <= 1'b0;
    end else begin
      state          <= n_state;
      tick_cnt       <= n_tick_cnt;
      wr_ptr         <= n_wr_ptr;
      rd_ptr         <= n_rd_ptr;
      fill_level     <= n_fill;
      out_sample     <= n_out_sample;
      out_strobe     <= n_strobe;
      underrun_count <= n_under_cnt;
      overflow_count <= n_over_cnt;
      red_cnt        <= n_red_cnt;
      blue_cnt       <= n_blue_cnt;
      RED_LED        <= (n_red_cnt != '0);
      GREEN_LED      <= (n_state == ST_RUN);
      BLUE_LED       <= (n_blue_cnt != '0);
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge input_clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_sample_rate_scheduler.sv
`timescale 1ns/1ps
module tb_sample_rate_scheduler;

  localparam int DATA_W   = 16;
  localparam int DEPTH    = 8;
  localparam int PREFILL  = 4;
  localparam int DIV      = 256;
  localparam int LED_HOLD = 1000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_sample;
  logic              out_strobe;
  logic [3:0]        fill_level;
  logic [15:0]       underrun_count;
  logic [15:0]       overflow_count;
  logic              red_led, green_led, blue_led;

  sample_rate_scheduler #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PREFILL(PREFILL), .DIV(DIV), .LED_HOLD(LED_HOLD)
  ) dut (
    .input_clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .out_sample(out_sample), .out_strobe(out_strobe), .fill_level(fill_level),
    .underrun_count(underrun_count), .overflow_count(overflow_count),
    .RED_LED(red_led), .GREEN_LED(green_led), .BLUE_LED(blue_led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a sample queue plus playback flag, counts and last-event times.
  logic [DATA_W-1:0] q[$];
  bit                m_run;
  int                m_under, m_over;
  int                last_red, last_blue;
  logic [DATA_W-1:0] m_out;
  bit                m_strobe;
  int                k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at edge %0d", tag, obs, exp, k);
    end
  endtask

  task automatic reset_model();
    q.delete();
    m_run = 0; m_under = 0; m_over = 0;
    last_red = -1; last_blue = -1;
    m_out = '0; m_strobe = 0; k = 0;
  endtask

  // Advance the model by one clock edge (edge index k since reset release).
  task automatic model_edge(input bit v, input logic [DATA_W-1:0] d);
    int  sz;
    bit  popped;
    sz = q.size();
    popped = 0;
    m_strobe = 0;
    if (k % DIV == DIV - 1) begin
      m_strobe = 1;
      if (!m_run) begin
        if (sz >= PREFILL) begin m_out = q.pop_front(); popped = 1; m_run = 1; end
        else m_out = '0;
      end else if (sz > 0) begin
        m_out = q.pop_front(); popped = 1;
      end else begin
        if (m_under < 65535) m_under++;
        last_red = k;
        m_run = 0;
      end
    end
    if (v) begin
      if (sz < DEPTH || popped) q.push_back(d);
      else begin
        if (m_over < 65535) m_over++;
        last_blue = k;
      end
    end
    k++;
  endtask

  task automatic check_all();
    int e;
    e = k - 1;
    chk("out_sample", 32'(out_sample), 32'(m_out));
    chk("out_strobe", 32'(out_strobe), 32'(m_strobe));
    chk("fill_level", 32'(fill_level), 32'(q.size()));
    chk("underrun_count", 32'(underrun_count), 32'(m_under));
    chk("overflow_count", 32'(overflow_count), 32'(m_over));
    chk("GREEN_LED", 32'(green_led), 32'(m_run));
    chk("RED_LED", 32'(red_led), 32'(last_red >= 0 && (e - last_red) < LED_HOLD));
    chk("BLUE_LED", 32'(blue_led), 32'(last_blue >= 0 && (e - last_blue) < LED_HOLD));
  endtask

  task automatic step(input bit v, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    model_edge(v, d);
    #1;
    check_all();
    in_valid = 1'b0;
  endtask

  task automatic idle_until(input int target);
    while (k < target) step(0, '0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_sample"}, 32'(out_sample), 32'd0);
    chk({tag, "_out_strobe"}, 32'(out_strobe), 32'd0);
    chk({tag, "_fill"}, 32'(fill_level), 32'd0);
    chk({tag, "_under"}, 32'(underrun_count), 32'd0);
    chk({tag, "_over"}, 32'(overflow_count), 32'd0);
    chk({tag, "_leds"}, 32'({red_led, green_led, blue_led}), 32'd0);
  endtask

  // Assert reset between edges, verify the asynchronous clear, release on a falling edge.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    check_reset_outputs(tag);
    reset_model();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    reset_model();

    // Idle after reset: muted strobes at the tick times, nothing playing.
    #23;
    do_reset("rst0");
    idle_until(3 * DIV + 4);

    // Four known samples prefilled, then one random sample per tick period.
    do_reset("rst1");
    step(1, 16'h1111); step(1, 16'h2222); step(1, 16'h3333); step(1, 16'h4444);
    idle_until(DIV);
    chk("first_sample", 32'(out_sample), 32'h1111);
    chk("first_green", 32'(green_led), 32'd1);
    for (int t = 1; t <= 6; t++) begin
      idle_until(t * DIV + int'($urandom_range(0, DIV - 2)));
      step(1, DATA_W'($urandom));
    end
    idle_until(8 * DIV);

    // Prefill then starve: four samples out, underrun holds, then mute.
    do_reset("rst2");
    for (int i = 0; i < 4; i++) step(1, DATA_W'($urandom));
    idle_until(5 * DIV);
    chk("underrun_count_1", 32'(underrun_count), 32'd1);
    chk("red_after_underrun", 32'(red_led), 32'd1);
    idle_until(8 * DIV + 2);

    // Ten back-to-back pushes while prefilling: two dropped, then playback.
    do_reset("rst3");
    for (int i = 0; i < 10; i++) step(1, DATA_W'($urandom));
    chk("fill_saturated", 32'(fill_level), 32'd8);
    chk("overflow_2", 32'(overflow_count), 32'd2);
    idle_until(5 * DIV + 2);

    // Full FIFO plus push on a RUN tick, then reset while playing with fill 5.
    do_reset("rst4");
    for (int i = 0; i < 8; i++) step(1, DATA_W'($urandom));
    idle_until(300);
    step(1, DATA_W'($urandom));
    idle_until(2 * DIV - 1);
    chk("full_before_tick", 32'(fill_level), 32'd8);
    step(1, DATA_W'($urandom));
    chk("full_after_tick_push", 32'(fill_level), 32'd8);
    chk("no_overflow_on_tick_push", 32'(overflow_count), 32'd0);
    idle_until(5 * DIV + 20);
    chk("fill_5_before_reset", 32'(fill_level), 32'd5);
    chk("green_before_reset", 32'(green_led), 32'd1);
    do_reset("rst_mid");
    idle_until(2 * DIV + 2);
    chk("muted_after_reset", 32'(out_sample), 32'd0);

    // Random traffic at several push rates (per 1024 cycles).
    do_reset("rst5");
    for (int seg = 0; seg < 4; seg++) begin
      int rate;
      rate = (seg == 0) ? 2 : (seg == 1) ? 4 : (seg == 2) ? 40 : 5;
      for (int c = 0; c < 1500; c++) begin
        if ($urandom_range(0, 1023) < rate) step(1, DATA_W'($urandom));
        else step(0, '0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
